// File: rtl/weight_train_seq.sv
// XOR training-run sequencer: presents samples, waits out the update pipeline, commits weights.
// One commit per PIPE_LATENCY+1 cycles; no backpressure. Optional macro WEIGHT_NAN_GUARD_EN.
module weight_train_seq #(
  parameter int PIPE_LATENCY = 24,
  parameter int N_EPOCH      = 1000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [31:0] iNEW_WEIGHT1_0,
  input  logic [31:0] iNEW_WEIGHT1_1,
  input  logic [31:0] iNEW_WEIGHT2_0,
  input  logic [31:0] iNEW_WEIGHT2_2,
  input  logic [31:0] iNEW_WEIGHT12_0,
  input  logic [31:0] iNEW_WEIGHT12_1,
  input  logic [31:0] iNEW_WEIGHT12_2,
  output logic [31:0] oWEIGHT1_0,
  output logic [31:0] oWEIGHT1_1,
  output logic [31:0] oWEIGHT2_0,
  output logic [31:0] oWEIGHT2_2,
  output logic [31:0] oWEIGHT12_0,
  output logic [31:0] oWEIGHT12_1,
  output logic [31:0] oWEIGHT12_2,
  output logic [31:0] oX1,
  output logic [31:0] oX2,
  output logic [31:0] oTARGET,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [15:0] oEPOCH,
  output logic [1:0]  oSAMPLE,
  output logic        oNAN_FLAG
);

  typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_WAIT, S_COMMIT, S_FIN} state_t;

  localparam logic [7:0]  WAIT_LAST   = 8'(PIPE_LATENCY - 2);
  localparam logic [15:0] EPOCH_LAST  = 16'(N_EPOCH - 1);
  localparam logic [31:0] FP_ONE      = 32'h3F800000;
  localparam logic [31:0] FP_POS_HALF = 32'h3F000000;
  localparam logic [31:0] FP_NEG_HALF = 32'hBF000000;
  // Weights 1_0, 2_0 and 12_0 start at -0.5, the rest at +0.5.
  localparam logic [6:0]  NEG_INIT    = 7'b0010101;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  sample_q, sample_d;
  logic [15:0] epoch_q, epoch_d;
  logic [31:0] x1_q, x1_d, x2_q, x2_d, tgt_q, tgt_d;
  logic [31:0] w_q [7];
  logic [31:0] w_d [7];
  logic [31:0] new_w [7];
  logic        start_ok;
  logic        commit_en;

  assign new_w[0] = iNEW_WEIGHT1_0;
  assign new_w[1] = iNEW_WEIGHT1_1;
  assign new_w[2] = iNEW_WEIGHT2_0;
  assign new_w[3] = iNEW_WEIGHT2_2;
  assign new_w[4] = iNEW_WEIGHT12_0;
  assign new_w[5] = iNEW_WEIGHT12_1;
  assign new_w[6] = iNEW_WEIGHT12_2;

  assign start_ok  = (state_q == S_IDLE) && iSTART && !iSTOP;
  // Abort takes priority over a coinciding commit.
  assign commit_en = (state_q == S_COMMIT) && !iSTOP;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_PRESENT;
      S_PRESENT: state_d = S_WAIT;
      S_WAIT:    if (wait_q == WAIT_LAST) state_d = S_COMMIT;
      S_COMMIT:  state_d = (sample_q == 2'd3 && epoch_q == EPOCH_LAST) ? S_FIN : S_PRESENT;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && iSTOP) state_d = S_IDLE;
  end

  always_comb begin
    oBUSY = (state_q != S_IDLE);
    oDONE = (state_q == S_FIN);
  end

  always_comb begin
    wait_d   = (state_q == S_WAIT) ? wait_q + 8'd1 : 8'd0;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    if (start_ok) begin
      sample_d = 2'd0;
      epoch_d  = 16'd0;
    end else if (commit_en) begin
      sample_d = sample_q + 2'd1;
      if (sample_q == 2'd3) epoch_d = epoch_q + 16'd1;
    end
    x1_d  = x1_q;
    x2_d  = x2_q;
    tgt_d = tgt_q;
    // Sample inputs latch only when entering PRESENT, so they stay stable through COMMIT.
    if (state_d == S_PRESENT) begin
      x1_d  = sample_d[1] ? FP_ONE : 32'h0;
      x2_d  = sample_d[0] ? FP_ONE : 32'h0;
      tgt_d = (sample_d[1] ^ sample_d[0]) ? FP_ONE : 32'h0;
    end
  end

`ifdef WEIGHT_NAN_GUARD_EN
  logic nan_q, nan_d;

  always_comb begin
    nan_d = nan_q;
    for (int i = 0; i < 7; i++) begin
      w_d[i] = w_q[i];
      if (commit_en) begin
        if (new_w[i][30:23] == 8'hFF) nan_d = 1'b1;
        else w_d[i] = new_w[i];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) nan_q <= 1'b0;
    else      nan_q <= nan_d;
  end

  assign oNAN_FLAG = nan_q;
`else
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_d[i] = commit_en ? new_w[i] : w_q[i];
    end
  end

  assign oNAN_FLAG = 1'b0;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wait_q   <= 8'd0;
      sample_q <= 2'd0;
      epoch_q  <= 16'd0;
      x1_q     <= 32'h0;
      x2_q     <= 32'h0;
      tgt_q    <= 32'h0;
      for (int i = 0; i < 7; i++) begin
        w_q[i] <= NEG_INIT[i] ? FP_NEG_HALF : FP_POS_HALF;
      end
    end else begin
      wait_q   <= wait_d;
      sample_q <= sample_d;
      epoch_q  <= epoch_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      tgt_q    <= tgt_d;
      for (int i = 0; i < 7; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign oWEIGHT1_0  = w_q[0];
  assign oWEIGHT1_1  = w_q[1];
  assign oWEIGHT2_0  = w_q[2];
  assign oWEIGHT2_2  = w_q[3];
  assign oWEIGHT12_0 = w_q[4];
  assign oWEIGHT12_1 = w_q[5];
  assign oWEIGHT12_2 = w_q[6];
  assign oX1         = x1_q;
  assign oX2         = x2_q;
  assign oTARGET     = tgt_q;
  assign oEPOCH      = epoch_q;
  assign oSAMPLE     = sample_q;

endmodule

// File: tb/tb_weight_train_seq.sv
// Bench for weight_train_seq: random weight updates against a cycle-position reference model.
module tb_weight_train_seq;

  localparam int PL = 4;
  localparam int NE = 2;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [31:0] nw [7];
  logic [31:0] ow [7];
  logic [31:0] x1, x2, tgt;
  logic        busy, done, nan;
  logic [15:0] epoch;
  logic [1:0]  sample;

  logic [31:0] m_w [7];
  logic        m_nan;
  logic [3:0]  x1_tab  = 4'b1100;
  logic [3:0]  x2_tab  = 4'b1010;
  logic [3:0]  tgt_tab = 4'b0110;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  weight_train_seq #(.PIPE_LATENCY(PL), .N_EPOCH(NE)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iSTOP(stop),
    .iNEW_WEIGHT1_0(nw[0]), .iNEW_WEIGHT1_1(nw[1]), .iNEW_WEIGHT2_0(nw[2]),
    .iNEW_WEIGHT2_2(nw[3]), .iNEW_WEIGHT12_0(nw[4]), .iNEW_WEIGHT12_1(nw[5]),
    .iNEW_WEIGHT12_2(nw[6]),
    .oWEIGHT1_0(ow[0]), .oWEIGHT1_1(ow[1]), .oWEIGHT2_0(ow[2]), .oWEIGHT2_2(ow[3]),
    .oWEIGHT12_0(ow[4]), .oWEIGHT12_1(ow[5]), .oWEIGHT12_2(ow[6]),
    .oX1(x1), .oX2(x2), .oTARGET(tgt), .oBUSY(busy), .oDONE(done),
    .oEPOCH(epoch), .oSAMPLE(sample), .oNAN_FLAG(nan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_w[0] = 32'hBF000000; m_w[1] = 32'h3F000000;
    m_w[2] = 32'hBF000000; m_w[3] = 32'h3F000000;
    m_w[4] = 32'hBF000000; m_w[5] = 32'h3F000000;
    m_w[6] = 32'h3F000000;
    m_nan  = 1'b0;
  endtask

  task automatic commit_model();
    for (int i = 0; i < 7; i++) begin
`ifdef WEIGHT_NAN_GUARD_EN
      if (nw[i][30:23] == 8'hFF) m_nan = 1'b1;
      else m_w[i] = nw[i];
`else
      m_w[i] = nw[i];
`endif
    end
  endtask

  // xs selects the sample whose X/target values are expected; negative means all zero.
  task automatic check_all(input int s, input int xs, input int ep, input int b, input int d);
    chk("busy", 32'(busy), 32'(b));
    chk("done", 32'(done), 32'(d));
    chk("sample", 32'(sample), 32'(s));
    chk("epoch", 32'(epoch), 32'(ep));
    chk("x1", x1, (xs < 0) ? 32'h0 : (x1_tab[xs] ? ONE : 32'h0));
    chk("x2", x2, (xs < 0) ? 32'h0 : (x2_tab[xs] ? ONE : 32'h0));
    chk("target", tgt, (xs < 0) ? 32'h0 : (tgt_tab[xs] ? ONE : 32'h0));
    for (int i = 0; i < 7; i++) chk($sformatf("weight%0d", i), ow[i], m_w[i]);
    chk("nan_flag", 32'(nan), 32'(m_nan));
  endtask

  // Called at a negedge in IDLE. stop_k: commit index to abort on; rst_rel: cycle to reset in.
  task automatic do_run(input int stop_k, input int rst_rel);
    int r, k, ph;
    r = 4 * NE * (PL + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int rel = 0; rel <= r; rel++) begin
      k  = rel / (PL + 1);
      ph = rel % (PL + 1);
      if (rel < r) check_all(k % 4, k % 4, k / 4, 1, 0);
      else         check_all(0, 3, NE, 1, 1);
      for (int i = 0; i < 7; i++) nw[i] = $urandom();
      start = (rel == PL + 2);
      if (rel < r && ph == PL) begin
        if (k == 0) nw[1] = 32'h3F400000;
        if (k == 1) nw[3] = 32'h7FC00000;
        if (k == stop_k) begin
          stop = 1'b1;
          @(negedge clk);
          stop = 1'b0;
          check_all(k % 4, k % 4, k / 4, 0, 0);
          return;
        end
        commit_model();
      end
      if (rel == rst_rel) begin
        rst   = 1'b1;
        start = 1'b0;
        #1;
        reset_model();
        check_all(0, -1, 0, 0, 0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_all(0, 3, NE, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 7; i++) nw[i] = 32'h0;
    reset_model();
    repeat (2) @(negedge clk);
    check_all(0, -1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all(0, -1, 0, 0, 0);

    do_run(-1, -1);

    do_run(2, -1);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_all(2, 2, 0, 0, 0);

    do_run(-1, 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all(0, -1, 0, 0, 0);

    do_run(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_train_seq.md
WEIGHT_TRAIN_SEQ -- requirements
Module: weight_train_seq

Interface
REQ-001 The block SHALL take parameter PIPE_LATENCY, default 24: cycles from sample presentation until the upstream weight-update pipeline's oWEIGHT* outputs are valid (legal range 2..255).
REQ-002 The block SHALL take parameter N_EPOCH, default 1000: number of 4-sample XOR epochs per training run (legal range 1..65535).
REQ-003 iCLK  in  1  single clock; all state updates on the rising edge.
REQ-004 iRST  in  1  asynchronous, active-high reset.
REQ-005 iSTART  in  1  one-cycle start pulse; honoured only in IDLE.
REQ-006 iSTOP  in  1  synchronous abort; returns the block to IDLE without committing.
REQ-007 iNEW_WEIGHT1_0, iNEW_WEIGHT1_1, iNEW_WEIGHT2_0, iNEW_WEIGHT2_2, iNEW_WEIGHT12_0, iNEW_WEIGHT12_1, iNEW_WEIGHT12_2  in  32 each  updated IEEE-754 single-precision weights from the update stage.
REQ-008 oWEIGHT1_0, oWEIGHT1_1, oWEIGHT2_0, oWEIGHT2_2, oWEIGHT12_0, oWEIGHT12_1, oWEIGHT12_2  out  32 each  registered current weights, fed to the forward and update stages.
REQ-009 oX1, oX2  out  32  current sample inputs (fp32 0.0 = 32'h00000000, 1.0 = 32'h3F800000).
REQ-010 oTARGET  out  32  XOR target for the current sample, same encoding as oX1/oX2.
REQ-011 oBUSY  out  1  high in every state except IDLE.
REQ-012 oDONE  out  1  one-cycle pulse on run completion.
REQ-013 oEPOCH  out  16  completed-epoch count.
REQ-014 oSAMPLE  out  2  current sample index.
REQ-015 oNAN_FLAG  out  1  sticky guard flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, PRESENT, WAIT, COMMIT and FIN.
REQ-017 Transitions SHALL be: IDLE->PRESENT on iSTART; PRESENT->WAIT (one cycle); WAIT->COMMIT after PIPE_LATENCY-1 WAIT cycles; COMMIT->FIN when oSAMPLE==3 and oEPOCH==N_EPOCH-1, else COMMIT->PRESENT; FIN->IDLE (one cycle).
REQ-018 Sample order SHALL be index 0:(0,0)->0, 1:(0,1)->1, 2:(1,0)->1, 3:(1,1)->0, for oX1, oX2 and oTARGET respectively.
REQ-019 oX1, oX2 and oTARGET SHALL be updated on entry to PRESENT and held constant through COMMIT.
REQ-020 If PRESENT is at cycle 0, COMMIT SHALL occur at cycle PIPE_LATENCY, at which point all seven iNEW_WEIGHT* values are registered into the oWEIGHT* outputs in the same edge.
REQ-021 oWEIGHT* SHALL change only at a COMMIT edge or on reset.
REQ-022 oSAMPLE SHALL increment at COMMIT and wrap from 3 to 0; on that wrap, oEPOCH SHALL increment.
REQ-023 On the final COMMIT, oEPOCH SHALL read N_EPOCH in FIN; oDONE SHALL be high during FIN only.
REQ-024 iSTART in IDLE SHALL clear oSAMPLE and oEPOCH but SHALL retain the weights, so repeated runs continue training.
REQ-025 iSTART outside IDLE SHALL be ignored.
REQ-026 iSTOP in any non-IDLE state SHALL force IDLE on the next edge with no commit and no oDONE pulse; counters SHALL hold.
REQ-027 If iSTOP and a COMMIT coincide, iSTOP SHALL win: no weight update occurs.
REQ-028 If iSTART and iSTOP are asserted together in IDLE, the block SHALL remain in IDLE.

Reset
REQ-029 iRST SHALL asynchronously force: state IDLE; oWEIGHT1_0, oWEIGHT2_0, oWEIGHT12_0 = 32'hBF000000 (-0.5); all other oWEIGHT* = 32'h3F000000 (0.5); oX1, oX2, oTARGET = 0; oBUSY, oDONE, oNAN_FLAG = 0; oEPOCH = 0; oSAMPLE = 0.
REQ-030 Reset asserted mid-run SHALL abandon the run immediately; the WAIT counter SHALL restart from zero on the next run.

Configuration
REQ-031 With macro WEIGHT_NAN_GUARD_EN defined: at COMMIT, any iNEW_WEIGHT* whose exponent field is 8'hFF SHALL not be written; that weight SHALL keep its old value, and oNAN_FLAG SHALL set and stay set until iRST.
REQ-032 Without WEIGHT_NAN_GUARD_EN: all seven weights SHALL be written unconditionally at COMMIT, and oNAN_FLAG SHALL be tied to 0.

Verification
REQ-033 Reset, then check outputs -> weights -0.5/0.5 per REQ-029; oBUSY=0; oEPOCH=0.
REQ-034 PIPE_LATENCY=4, N_EPOCH=2, one iSTART pulse -> 8 COMMITs spaced 5 cycles apart; X/target follow REQ-018; oDONE pulses once with oEPOCH=2.
REQ-035 iNEW_WEIGHT1_1=32'h3F400000 held at COMMIT -> oWEIGHT1_1=32'h3F400000 the cycle after COMMIT and unchanged during the following WAIT.
REQ-036 iSTOP asserted in the COMMIT cycle of sample 2 -> weights unchanged, state IDLE, oSAMPLE=2, no oDONE.
REQ-037 With WEIGHT_NAN_GUARD_EN, iNEW_WEIGHT2_2=32'h7FC00000 at COMMIT -> oWEIGHT2_2 keeps its old value, oNAN_FLAG=1, other weights update.
REQ-038 iRST asserted during WAIT, then iSTART -> first COMMIT exactly PIPE_LATENCY cycles after the new PRESENT, with reset weights as the base.
